// File: rtl/pool2x2_seq.sv
// pool2x2_seq -- streaming 2x2, stride-2 max-pooling sequencer for
// sign-magnitude feature maps (MSB = sign, remaining bits = magnitude).
// Pixels arrive one per cycle in raster order. The horizontal maxima of each
// even row are parked in a half-width line buffer. The matching odd row
// finishes each window and loads one pooled pixel into the output register.
// Optional build macro: POOL_RELU_EN -- when defined, pooled results with the
// sign bit set (all negatives and -0) are replaced by +0 (fused ReLU).

// Two-input sign-magnitude maximum. +0 beats -0.
module max_pool #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_max
);

  logic                  w_sa;
  logic                  w_sb;
  logic [DATA_WIDTH-2:0] w_ma;
  logic [DATA_WIDTH-2:0] w_mb;
  logic                  w_a_wins;

  assign w_sa = i_a[DATA_WIDTH-1];
  assign w_sb = i_b[DATA_WIDTH-1];
  assign w_ma = i_a[DATA_WIDTH-2:0];
  assign w_mb = i_b[DATA_WIDTH-2:0];

  // Decide the winner from the two sign bits, then from the magnitudes.
  always_comb begin
    w_a_wins = 1'b0;
    case ({w_sa, w_sb})
      2'b01:   w_a_wins = 1'b1;          // a non-negative, b negative
      2'b10:   w_a_wins = 1'b0;          // a negative, b non-negative
      2'b00:   w_a_wins = (w_ma >= w_mb); // both positive: larger magnitude
      default: w_a_wins = (w_ma <= w_mb); // both negative: smaller magnitude
    endcase
  end

  assign o_max = w_a_wins ? i_a : i_b;

endmodule

module pool2x2_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_W      = 64,
  parameter int MAX_H      = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [$clog2(MAX_W+1)-1:0]   cfg_width,
  input  logic [$clog2(MAX_H+1)-1:0]   cfg_height,
  output logic                         busy,
  output logic                         done,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last
);

  localparam int WW       = $clog2(MAX_W+1);
  localparam int HW       = $clog2(MAX_H+1);
  localparam int LB_DEPTH = MAX_W / 2;
  localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [WW-1:0] W_ONE = WW'(1);
  localparam logic [WW-1:0] W_TWO = WW'(2);
  localparam logic [WW-1:0] W_MAX = WW'(MAX_W);
  localparam logic [HW-1:0] H_ONE = HW'(1);
  localparam logic [HW-1:0] H_TWO = HW'(2);
  localparam logic [HW-1:0] H_MAX = HW'(MAX_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVEN,
    S_ODD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [WW-1:0]         r_width;
  logic [HW-1:0]         r_height;
  logic [WW-1:0]         r_col;
  logic [HW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;

  // Half-width line buffer: one horizontal maximum per column pair.
  logic [DATA_WIDTH-1:0] r_linebuf [LB_DEPTH];

  logic [WW-1:0]         w_cfg_w;
  logic [HW-1:0]         w_cfg_h;
  logic                  w_cfg_bad;
  logic                  w_xfer;
  logic                  w_col_last;
  logic                  w_row_last;
  logic [LBW-1:0]        w_lb_idx;
  logic [DATA_WIDTH-1:0] w_lb_rd;
  logic [DATA_WIDTH-1:0] w_hmax;
  logic [DATA_WIDTH-1:0] w_vmax;
  logic [DATA_WIDTH-1:0] w_pool_out;
  logic                  w_lb_we;
  logic                  w_out_load;

  // Frame dimensions are rounded down to even before the legality check.
  assign w_cfg_w   = cfg_width & ~W_ONE;
  assign w_cfg_h   = cfg_height & ~H_ONE;
  assign w_cfg_bad = (w_cfg_w < W_TWO) || (w_cfg_w > W_MAX) ||
                     (w_cfg_h < H_TWO) || (w_cfg_h > H_MAX);

  // Output stalls only block ODD-row input: EVEN rows never touch the
  // output register, so they keep streaming into the line buffer.
  assign in_ready = (r_state == S_EVEN) ||
                    ((r_state == S_ODD) && !(r_out_valid && !out_ready));

  assign w_xfer     = in_valid && in_ready;
  assign w_col_last = (r_col == (r_width - W_ONE));
  assign w_row_last = (r_row == (r_height - H_ONE));
  assign w_lb_idx   = LBW'(r_col >> 1);
  assign w_lb_rd    = r_linebuf[w_lb_idx];

  assign w_lb_we    = w_xfer && (r_state == S_EVEN) && r_col[0];
  assign w_out_load = w_xfer && (r_state == S_ODD) && r_col[0];

  max_pool #(.DATA_WIDTH(DATA_WIDTH)) u_hmax (
    .i_a   (r_hold),
    .i_b   (in_data),
    .o_max (w_hmax)
  );

  max_pool #(.DATA_WIDTH(DATA_WIDTH)) u_vmax (
    .i_a   (w_hmax),
    .i_b   (w_lb_rd),
    .o_max (w_vmax)
  );

`ifdef POOL_RELU_EN
  assign w_pool_out = w_vmax[DATA_WIDTH-1] ? '0 : w_vmax;
`else
  assign w_pool_out = w_vmax;
`endif

  // Line buffer write: even-row horizontal maxima, no reset on contents.
  always_ff @(posedge clk) begin
    if (w_lb_we) begin
      r_linebuf[w_lb_idx] <= w_hmax;
    end
  end

  // Sequencer: frame state, raster counters, hold register and output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_width     <= '0;
      r_height    <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_hold      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      // A consumed output drops valid; a same-cycle reload below overrides.
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end

      if (w_xfer) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= r_row + H_ONE;
        end else begin
          r_col <= r_col + W_ONE;
        end
        if (!r_col[0]) begin
          r_hold <= in_data;
        end
      end

      if (w_out_load) begin
        r_out_data  <= w_pool_out;
        r_out_valid <= 1'b1;
        r_out_last  <= w_row_last && w_col_last;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_width  <= w_cfg_w;
            r_height <= w_cfg_h;
            r_col    <= '0;
            r_row    <= '0;
            r_state  <= w_cfg_bad ? S_DONE : S_EVEN;
          end
        end
        S_EVEN: begin
          if (w_xfer && w_col_last) begin
            r_state <= S_ODD;
          end
        end
        S_ODD: begin
          if (w_xfer && w_col_last) begin
            r_state <= w_row_last ? S_DRAIN : S_EVEN;
          end
        end
        S_DRAIN: begin
          if (r_out_valid && out_ready) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = (r_state == S_EVEN) || (r_state == S_ODD) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_pool2x2_seq.sv
// Testbench for pool2x2_seq: randomized and directed frames checked against a
// window-level pooling model (plain array maxima over each 2x2 block).
`timescale 1ns/1ps
module tb_pool2x2_seq;

  localparam int DW = 16;
  localparam int MW = 64;
  localparam int MH = 64;
  localparam int WW = $clog2(MW+1);
  localparam int HW = $clog2(MH+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [WW-1:0] cfg_width = '0;
  logic [HW-1:0] cfg_height = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;

  always #5 clk = ~clk;

  pool2x2_seq #(.DATA_WIDTH(DW), .MAX_W(MW), .MAX_H(MH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .busy       (busy),
    .done       (done),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] pix [MH][MW];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            start_cyc = 0;
  int            done_cyc = 0;
  int            ready_mode = 0;   // 0: ready high, 1: random, 2: driven by feed
  bit            illegal_armed = 1'b0;
  bit            prev_hs_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, got, expv);
    end
  endtask

  // Total order on sign-magnitude values: +0 ranks just above -0.
  function automatic int rank(input logic [DW-1:0] x);
    int m;
    m = int'(x[DW-2:0]);
    return x[DW-1] ? -2 * m : 2 * m + 1;
  endfunction

  function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (rank(b) > rank(a)) ? b : a;
  endfunction

  task automatic build_model(input int w, input int h);
    exp_t e;
    logic [DW-1:0] m;
    for (int r = 0; r < h; r += 2) begin
      for (int c = 0; c < w; c += 2) begin
        m = smax(smax(pix[r][c], pix[r][c+1]), smax(pix[r+1][c], pix[r+1][c+1]));
`ifdef POOL_RELU_EN
        if (m[DW-1]) m = '0;
`endif
        e.d = m;
        e.l = (r == h - 2) && (c == w - 2);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic fill_random(input int w, input int h);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        case ($urandom_range(0, 7))
          0:       pix[r][c] = 16'h8000;
          1:       pix[r][c] = 16'h0000;
          default: pix[r][c] = DW'($urandom);
        endcase
      end
    end
  endtask

  // Free-running cycle counter (posedges).
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output-ready generator.
  initial forever begin
    @(posedge clk);
    #1;
    if (ready_mode == 0) out_ready = 1'b1;
    else if (ready_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Compare process: every output handshake against the model queue,
  // plus the done pulse following the final handshake.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hs_last = 1'b0;
      end else begin
        if (prev_hs_last) begin
          chk("done_after_last", done, 1);
          chk("idle_after_last", busy, 0);
        end else if (done && !illegal_armed) begin
          chk("unexpected_done", done, 0);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_output", out_valid, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_last", out_last, e.l);
            $display("out data=0x%04h last=%0d want=0x%04h", out_data, out_last, e.d);
          end
        end
        prev_hs_last = out_valid && out_ready && out_last;
      end
    end
  end

  task automatic do_start(input int cw, input int ch);
    start      = 1'b1;
    cfg_width  = WW'(cw);
    cfg_height = HW'(ch);
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic feed(input int w, input int npix, input bit gaps, input int stall_at);
    int i = 0;
    int guard = 0;
    int stall_left = 0;
    bit stall_used = 1'b0;
    bit xfer;
    while (i < npix && guard < 20000) begin
      if (i == stall_at && !stall_used) begin
        stall_used = 1'b1;
        stall_left = 10;
        ready_mode = 2;
        out_ready  = 1'b0;
      end
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = pix[i / w][i % w];
      @(negedge clk);
      xfer = in_valid && in_ready;
      if (stall_left > 0 && out_valid) chk("stall_in_ready", in_ready, 0);
      if (xfer && ((i / w) % 2 == 1) && (i % 2 == 1) && out_valid && !out_ready)
        chk("overwrite_guard", in_ready, 0);
      @(posedge clk);
      #1;
      if (xfer) i++;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) begin
          ready_mode = 0;
          out_ready  = 1'b1;
        end
      end
      guard++;
    end
    in_valid = 1'b0;
    if (i < npix) chk("feed_timeout", i, npix);
  endtask

  task automatic wait_done();
    int n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    if (n >= 2000) chk("done_timeout", done, 1);
    done_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int cw, input int ch, input bit gaps, input int rmode, input int stall_at);
    int w;
    int h;
    w = cw & ~1;
    h = ch & ~1;
    ready_mode = rmode;
    do_start(cw, ch);
    chk("start_busy", busy, 1);
    chk("start_in_ready", in_ready, 1);
    feed(w, w * h, gaps, stall_at);
    wait_done();
    chk("queue_empty", exp_q.size(), 0);
    ready_mode = 0;
    out_ready  = 1'b1;
    $display("frame %0dx%0d complete", w, h);
  endtask

  task automatic illegal(input int cw, input int ch);
    illegal_armed = 1'b1;
    do_start(cw, ch);
    chk("ill_done", done, 1);
    chk("ill_busy", busy, 0);
    chk("ill_in_ready", in_ready, 0);
    chk("ill_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    chk("ill_done_clear", done, 0);
    chk("ill_busy_after", busy, 0);
    illegal_armed = 1'b0;
    $display("illegal config w=%0d h=%0d", cw, ch);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin : main
    int rw;
    int rh;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);

    // 4x4 ramp 1..16.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        pix[r][c] = DW'(r * 4 + c + 1);
    build_model(4, 4);
    chk("pin_ramp0", exp_q[0].d, 6);
    chk("pin_ramp1", exp_q[1].d, 8);
    chk("pin_ramp2", exp_q[2].d, 14);
    chk("pin_ramp3", exp_q[3].d, 16);
    chk("pin_ramp3_last", exp_q[3].l, 1);
    go(4, 4, 1'b0, 0, -1);
    chk("thru_4x4", done_cyc - start_cyc, 17);

    // Single negative window.
    pix[0][0] = 16'h8003; pix[0][1] = 16'h8001;
    pix[1][0] = 16'h8005; pix[1][1] = 16'h8002;
    build_model(2, 2);
`ifdef POOL_RELU_EN
    chk("pin_neg", exp_q[0].d, 16'h0000);
`else
    chk("pin_neg", exp_q[0].d, 16'h8001);
`endif
    go(2, 2, 1'b0, 0, -1);

    // +0 against -0.
    pix[0][0] = 16'h8000; pix[0][1] = 16'h0000;
    pix[1][0] = 16'h8007; pix[1][1] = 16'h8000;
    build_model(2, 2);
    chk("pin_zero", exp_q[0].d, 16'h0000);
    go(2, 2, 1'b0, 0, -1);

    // 8x4 with a 10-cycle output stall in the first odd row.
    fill_random(8, 4);
    build_model(8, 4);
    go(8, 4, 1'b0, 0, 11);

    // Illegal configurations.
    illegal(1, 4);
    illegal(4, 0);
    illegal(66, 4);
    illegal(4, 66);

    // Odd configuration rounds down to 4x2.
    fill_random(4, 2);
    build_model(4, 2);
    go(5, 3, 1'b1, 1, -1);

    // Maximum width and maximum height.
    fill_random(64, 2);
    build_model(64, 2);
    go(64, 2, 1'b1, 1, -1);
    fill_random(4, 64);
    build_model(4, 64);
    go(4, 64, 1'b1, 1, -1);

    // Random frames with input gaps and output backpressure.
    for (int k = 0; k < 6; k++) begin
      rw = 2 * $urandom_range(1, 8);
      rh = 2 * $urandom_range(1, 8);
      fill_random(rw, rh);
      build_model(rw, rh);
      go(rw, rh, 1'b1, 1, -1);
    end

    // Reset midway through an 8x8 frame, then a fresh 4x4 frame.
    fill_random(8, 8);
    build_model(8, 8);
    ready_mode = 0;
    do_start(8, 8);
    feed(8, 40, 1'b0, -1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_done", done, 0);
    $display("reset mid-frame applied");
    fill_random(4, 4);
    build_model(4, 4);
    go(4, 4, 1'b0, 0, -1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
